// File: rtl/pe_os_drain.sv
// pe_os_drain: result-collection end of an output-stationary PE row.
// Holds the row's clear line while idle, releases it for accumulation,
// snapshots every PE result a fixed skew after the last operand beat and
// streams the snapshot out one word per valid/ready handshake.
module pe_os_drain #(
  parameter int NUM_PE         = 4,
  parameter int DATA_WIDTH_OUT = 32,
  parameter int DRAIN_LAT      = 4,
  parameter int IDX_W          = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic                             done_i,
  input  logic [NUM_PE*DATA_WIDTH_OUT-1:0] mac_res_i,
  output logic                             clear_o,
  output logic                             res_valid_o,
  input  logic                             res_ready_i,
  output logic [DATA_WIDTH_OUT-1:0]        res_data_o,
  output logic [IDX_W-1:0]                 res_idx_o,
  output logic                             res_last_o,
  output logic                             busy_o,
  output logic                             drop_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC    = 2'd1,
    WAIT   = 2'd2,
    STREAM = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);
  // Counter preload; the capture itself takes the final edge, hence the -1.
  localparam logic [7:0]       LAT_M1   = (DRAIN_LAT > 0) ? 8'(DRAIN_LAT - 1) : 8'd0;
  localparam bit               ZERO_LAT = (DRAIN_LAT == 0);

  state_t                    state_q;
  logic [7:0]                cnt_q;
  logic                      clear_q;
  logic                      valid_q;
  logic                      last_q;
  logic                      drop_q;
  logic [DATA_WIDTH_OUT-1:0] data_q;
  logic [IDX_W-1:0]          idx_q;

  logic [DATA_WIDTH_OUT-1:0] pe_res   [NUM_PE];
  logic [DATA_WIDTH_OUT-1:0] shadow_q [NUM_PE];

  logic                      capture;
  logic                      handshake;
  logic [IDX_W-1:0]          idx_d;

  // Unpack the flat PE result bus into one word per PE.
  for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_unpack
    assign pe_res[gi] = mac_res_i[gi*DATA_WIDTH_OUT +: DATA_WIDTH_OUT];
  end

  // Snapshot strobe: either straight from done_i (zero skew) or at the end of WAIT.
  always_comb begin
    capture   = 1'b0;
    handshake = valid_q & res_ready_i;
    idx_d     = idx_q + IDX_W'(1);
    if ((state_q == ACC) && done_i && ZERO_LAT) begin
      capture = 1'b1;
    end
    if ((state_q == WAIT) && (cnt_q == 8'd0)) begin
      capture = 1'b1;
    end
  end

  // Shadow registers: loaded only on capture, so later PE activity cannot leak into the stream.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_PE; k++) begin
        shadow_q[k] <= '0;
      end
    end else if (capture) begin
      for (int k = 0; k < NUM_PE; k++) begin
        shadow_q[k] <= pe_res[k];
      end
    end
  end

  // Control FSM with registered clear, stream outputs and drop indication.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      clear_q <= 1'b1;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      drop_q  <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
    end else begin
      drop_q <= 1'b0;

      // Shared capture action: word 0 goes out on the same edge the snapshot is taken.
      if (capture) begin
        clear_q <= 1'b1;
        state_q <= STREAM;
        valid_q <= 1'b1;
        idx_q   <= '0;
        data_q  <= pe_res[0];
        last_q  <= (NUM_PE == 1);
      end

      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= ACC;
            clear_q <= 1'b0;
          end
          if (done_i) begin
            drop_q <= 1'b1;
          end
        end

        ACC: begin
          if (done_i && !ZERO_LAT) begin
            state_q <= WAIT;
            cnt_q   <= LAT_M1;
          end
          if (start_i) begin
            drop_q <= 1'b1;
          end
        end

        WAIT: begin
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end
          if (start_i || done_i) begin
            drop_q <= 1'b1;
          end
        end

        STREAM: begin
          if (handshake) begin
            if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              idx_q  <= idx_d;
              data_q <= shadow_q[idx_d];
              last_q <= (idx_d == LAST_IDX);
            end
          end
          if (start_i || done_i) begin
            drop_q <= 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign clear_o     = clear_q;
  assign res_valid_o = valid_q;
  assign res_data_o  = data_q;
  assign res_idx_o   = idx_q;
  assign res_last_o  = last_q;
  assign drop_o      = drop_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_pe_os_drain.sv
// Testbench for pe_os_drain: default 4-PE row plus a 1-PE zero-skew instance.
// Expected words are queued when results are presented and popped on handshakes.
module tb_pe_os_drain;

  logic         clk_i = 1'b0;
  logic         rst_i;

  logic         start_i, done_i, res_ready_i;
  logic [127:0] mac_res_i;
  logic         clear_o, res_valid_o, res_last_o, busy_o, drop_o;
  logic [31:0]  res_data_o;
  logic [1:0]   res_idx_o;

  logic         s_start, s_done, s_ready;
  logic [31:0]  s_mac;
  logic         s_clear, s_valid, s_last, s_busy, s_drop;
  logic [31:0]  s_data;
  logic [0:0]   s_idx;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  idx;
    logic        last;
  } exp_t;

  exp_t sb_q[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;

  always #5 clk_i = ~clk_i;

  pe_os_drain #(.NUM_PE(4), .DATA_WIDTH_OUT(32), .DRAIN_LAT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .done_i(done_i),
    .mac_res_i(mac_res_i), .clear_o(clear_o), .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i), .res_data_o(res_data_o), .res_idx_o(res_idx_o),
    .res_last_o(res_last_o), .busy_o(busy_o), .drop_o(drop_o)
  );

  pe_os_drain #(.NUM_PE(1), .DATA_WIDTH_OUT(32), .DRAIN_LAT(0)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(s_start), .done_i(s_done),
    .mac_res_i(s_mac), .clear_o(s_clear), .res_valid_o(s_valid),
    .res_ready_i(s_ready), .res_data_o(s_data), .res_idx_o(s_idx),
    .res_last_o(s_last), .busy_o(s_busy), .drop_o(s_drop)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_words(input logic [127:0] mac);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.data = mac[k*32 +: 32];
      e.idx  = 2'(k);
      e.last = (k == 3);
      sb_q.push_back(e);
    end
  endtask

  task automatic start_job();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    vec_cnt++;
    if (clear_o !== 1'b0 || busy_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL start_release: clear=%b busy=%b, want clear=0 busy=1", clear_o, busy_o);
    end
  endtask

  // Streams words off the default DUT following a ready pattern; stops after max_hs handshakes if nonzero.
  task automatic stream_words(input logic [15:0] pat, input int plen, input int max_hs, output int hs);
    int          c;
    logic        held_v;
    logic [31:0] hd;
    logic [1:0]  hi;
    logic        hl;
    exp_t        e;
    c = 0; hs = 0; held_v = 1'b0; hd = '0; hi = '0; hl = 1'b0;
    while (c < 64) begin
      if (held_v) begin
        vec_cnt++;
        if (res_valid_o !== 1'b1 || res_data_o !== hd || res_idx_o !== hi || res_last_o !== hl) begin
          err_cnt++;
          $display("FAIL stall_hold: v=%b data=%h idx=%0d last=%b, want v=1 data=%h idx=%0d last=%b",
                   res_valid_o, res_data_o, res_idx_o, res_last_o, hd, hi, hl);
        end
      end
      if (res_valid_o !== 1'b1) break;
      res_ready_i = pat[c % plen];
      if (res_ready_i) begin
        vec_cnt++;
        if (sb_q.size() == 0) begin
          err_cnt++;
          $display("FAIL extra_word: data=%h idx=%0d, want no word", res_data_o, res_idx_o);
        end else begin
          e = sb_q.pop_front();
          if (res_data_o !== e.data || res_idx_o !== e.idx || res_last_o !== e.last) begin
            err_cnt++;
            $display("FAIL word: data=%h idx=%0d last=%b, want data=%h idx=%0d last=%b",
                     res_data_o, res_idx_o, res_last_o, e.data, e.idx, e.last);
          end else begin
            $display("word idx=%0d data=%h last=%b ok", res_idx_o, res_data_o, res_last_o);
          end
        end
        hs++;
        held_v = 1'b0;
      end else begin
        held_v = 1'b1;
        hd = res_data_o; hi = res_idx_o; hl = res_last_o;
      end
      tick();
      c++;
      if (max_hs != 0 && hs == max_hs) break;
    end
    res_ready_i = 1'b0;
    if (c >= 64) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL stream_timeout: valid=%b after 64 cycles, want stream finished", res_valid_o);
    end
  endtask

  // Full job on the default DUT: accumulate, done, skew wait, capture, stream.
  task automatic run_job(input logic [127:0] mac, input logic [15:0] pat, input int plen, input bit mod_after);
    int hs;
    start_job();
    tick();
    tick();
    mac_res_i = mac;
    push_words(mac);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      vec_cnt++;
      if (res_valid_o !== 1'b0 || clear_o !== 1'b0) begin
        err_cnt++;
        $display("FAIL wait_phase %0d: valid=%b clear=%b, want 0 0", i, res_valid_o, clear_o);
      end
    end
    tick();
    vec_cnt++;
    if (res_valid_o !== 1'b1 || clear_o !== 1'b1 || busy_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL capture_edge: valid=%b clear=%b busy=%b, want 1 1 1", res_valid_o, clear_o, busy_o);
    end
    if (mod_after) mac_res_i = {4{32'h12345678}};
    stream_words(pat, plen, 0, hs);
    vec_cnt++;
    if (hs != 4 || busy_o !== 1'b0 || res_valid_o !== 1'b0 || sb_q.size() != 0) begin
      err_cnt++;
      $display("FAIL job_end: hs=%0d busy=%b valid=%b left=%0d, want 4 0 0 0", hs, busy_o, res_valid_o, sb_q.size());
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    vec_cnt++;
    if (clear_o !== 1'b1 || res_valid_o !== 1'b0 || res_data_o !== 32'd0 || res_idx_o !== 2'd0 ||
        res_last_o !== 1'b0 || busy_o !== 1'b0 || drop_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_state: clear=%b v=%b data=%h idx=%0d last=%b busy=%b drop=%b, want 1 0 0 0 0 0 0",
               clear_o, res_valid_o, res_data_o, res_idx_o, res_last_o, busy_o, drop_o);
    end
    vec_cnt++;
    if (s_clear !== 1'b1 || s_valid !== 1'b0 || s_busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_state_1pe: clear=%b v=%b busy=%b, want 1 0 0", s_clear, s_valid, s_busy);
    end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_drop();
    int hs;
    logic [127:0] mac;
    // done in IDLE
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    vec_cnt++;
    if (drop_o !== 1'b1 || busy_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL drop_idle: drop=%b busy=%b, want 1 0", drop_o, busy_o);
    end
    tick();
    vec_cnt++;
    if (drop_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL drop_width: drop=%b, want 0", drop_o);
    end
    // start during WAIT
    mac = {32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 32'h0000_0044};
    start_job();
    tick();
    mac_res_i = mac;
    push_words(mac);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    vec_cnt++;
    if (drop_o !== 1'b1 || busy_o !== 1'b1 || res_valid_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL drop_wait: drop=%b busy=%b valid=%b, want 1 1 0", drop_o, busy_o, res_valid_o);
    end
    tick();
    tick();
    tick();
    vec_cnt++;
    if (res_valid_o !== 1'b1 || clear_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL drop_wait_capture: valid=%b clear=%b, want 1 1", res_valid_o, clear_o);
    end
    // done during STREAM with ready low
    res_ready_i = 1'b0;
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    vec_cnt++;
    if (drop_o !== 1'b1 || res_valid_o !== 1'b1 || res_idx_o !== 2'd0 || res_data_o !== 32'h0000_0044) begin
      err_cnt++;
      $display("FAIL drop_stream: drop=%b valid=%b idx=%0d data=%h, want 1 1 0 00000044",
               drop_o, res_valid_o, res_idx_o, res_data_o);
    end
    stream_words(16'h0001, 1, 0, hs);
    vec_cnt++;
    if (hs != 4 || busy_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL drop_job_end: hs=%0d busy=%b, want 4 0", hs, busy_o);
    end
  endtask

  task automatic test_single();
    exp_t e;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    vec_cnt++;
    if (s_clear !== 1'b0 || s_busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL single_start: clear=%b busy=%b, want 0 1", s_clear, s_busy);
    end
    tick();
    s_mac = 32'd5;
    e.data = 32'd5; e.idx = 2'd0; e.last = 1'b1;
    sb_q.push_back(e);
    s_done = 1'b1;
    tick();
    s_done = 1'b0;
    e = sb_q.pop_front();
    vec_cnt++;
    if (s_valid !== 1'b1 || s_data !== e.data || s_idx !== e.idx[0] || s_last !== e.last || s_clear !== 1'b1) begin
      err_cnt++;
      $display("FAIL single_word: v=%b data=%h idx=%0d last=%b clear=%b, want 1 %h %0d %b 1",
               s_valid, s_data, s_idx, s_last, s_clear, e.data, e.idx, e.last);
    end else begin
      $display("word 1pe idx=0 data=%h last=1 ok", s_data);
    end
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0;
    vec_cnt++;
    if (s_valid !== 1'b0 || s_busy !== 1'b0 || s_last !== 1'b0) begin
      err_cnt++;
      $display("FAIL single_end: v=%b busy=%b last=%b, want 0 0 0", s_valid, s_busy, s_last);
    end
  endtask

  task automatic test_reset_mid();
    int hs;
    logic [127:0] mac;
    mac = {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};
    start_job();
    tick();
    mac_res_i = mac;
    push_words(mac);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    repeat (4) tick();
    stream_words(16'h0001, 1, 2, hs);
    #2;
    rst_i = 1'b1;
    #1;
    vec_cnt++;
    if (clear_o !== 1'b1 || res_valid_o !== 1'b0 || busy_o !== 1'b0 || res_last_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL async_reset: clear=%b valid=%b busy=%b last=%b, want 1 0 0 0",
               clear_o, res_valid_o, busy_o, res_last_o);
    end
    sb_q.delete();
    #2;
    rst_i = 1'b0;
    tick();
    run_job({32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0}, 16'h0001, 1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pe0;
    rst_i = 1'b1;
    start_i = 1'b0; done_i = 1'b0; res_ready_i = 1'b0; mac_res_i = '0;
    s_start = 1'b0; s_done = 1'b0; s_ready = 1'b0; s_mac = '0;

    pe0 = 32'd0;
    for (int k = 0; k < 4; k++) pe0 += 32'(k) * 32'(k + 1);

    test_reset();
    run_job({32'hFFFF_FFFF, 32'h0, 32'd7, pe0}, 16'h0001, 1, 1'b0);
    run_job({32'hFFFF_FFFF, 32'h0, 32'd7, pe0}, 16'b1101001, 7, 1'b0);
    run_job({32'hCAFE_0004, 32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001}, 16'h0001, 1, 1'b1);
    test_single();
    test_drop();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pe_os_drain.md
Name: pe_os_drain

Overview:
Result-collection end of the output-stationary PE interface.
- Owns the clear line of a row of NUM_PE pe_os instances and holds it high while idle.
- Releases clear for accumulation.
- After the last operand beat, waits for array skew to settle, snapshots every mac_res_o into shadow registers and re-asserts clear.
- Streams the snapshot out one word per valid/ready handshake, towards the output buffer / writeback path.

Parameters:
NUM_PE, 4, number of PEs in the row (>=1)
DATA_WIDTH_OUT, 32, width of each PE accumulator result
DRAIN_LAT, 4, cycles between done_i sample and result snapshot (0..255)
IDX_W, $clog2(NUM_PE) min 1, width of res_idx_o (derived)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
start_i  in  1  pulse: begin accumulation (release clear)
done_i  in  1  pulse: last operand beat has entered the row
mac_res_i  in  NUM_PE*DATA_WIDTH_OUT  packed PE results, PE k at bits [k*W +: W]
clear_o  out  1  to all PE clear_i; 1 = accumulators held at zero
res_valid_o  out  1  result word valid
res_ready_i  in  1  downstream accepts word
res_data_o  out  DATA_WIDTH_OUT  result word
res_idx_o  out  IDX_W  PE index of res_data_o
res_last_o  out  1  high with the word for PE NUM_PE-1
busy_o  out  1  state != IDLE
drop_o  out  1  one-cycle pulse: start_i/done_i ignored

Behaviour:
- Reset (async assert, sync use after release): state=IDLE, clear_o=1, res_valid_o=0, res_data_o=0, res_idx_o=0, res_last_o=0, drop_o=0, wait counter=0, shadow regs=0.
- All outputs registered. busy_o is decoded from the registered state.
- States: IDLE, ACC, WAIT, STREAM.
- IDLE:
  - start_i -> ACC, clear_o<=0.
  - done_i alone -> drop_o pulse, stay IDLE.
  - start_i and done_i together -> start wins, drop_o pulses.
- ACC:
  - done_i with DRAIN_LAT>0 -> WAIT, counter<=DRAIN_LAT-1.
  - done_i with DRAIN_LAT=0 -> capture on this same edge (see CAPTURE).
  - start_i -> drop_o pulse, no state change.
- WAIT:
  - counter decrements each cycle.
  - At counter==0: CAPTURE. Net effect: mac_res_i is sampled exactly DRAIN_LAT edges after the done_i edge.
  - start_i or done_i -> drop_o pulse, ignored.
- CAPTURE (action on a transition edge, not a separate state):
  - shadow[k]<=mac_res_i[k] for all k.
  - clear_o<=1, state<=STREAM.
  - res_valid_o<=1, res_idx_o<=0, res_data_o<=mac_res_i[0], res_last_o<=(NUM_PE==1).
- STREAM:
  - Handshake = res_valid_o & res_ready_i.
  - While valid & !ready: data, idx and last held stable.
  - On a handshake with idx<NUM_PE-1: idx+1, data<=shadow[idx+1], last<=(idx+1==NUM_PE-1).
  - On a handshake with last=1: res_valid_o<=0, res_last_o<=0, -> IDLE.
  - Max throughput: one word per cycle with ready tied high.
  - Shadow regs are isolated from mac_res_i changes after capture.
  - start_i or done_i -> drop_o pulse, ignored. A new job starts only from IDLE (start_i allowed in the cycle after the last handshake).
- Results pass through unmodified: no truncation, saturation or sign handling.
- Reset mid-operation: immediate return to reset values. Any in-flight stream is abandoned with no partial last. clear_o=1 zeroes the PEs.
- drop_o is high for exactly the cycle after the ignored input edge. It pulses once per ignored cycle.

Test Plan:
- Reset then start_i; drive PE model with active 0..3 / weight 1..4, done_i; mac_res_i = {0xFFFFFFFF, 0, 7, 20} (PE3..PE0); ready=1 -> capture 4 edges after done; clear_o rises on the capture edge; outputs 20,7,0,0xFFFFFFFF with idx 0..3; last only on idx 3; IDLE after.
- Same with ready toggling 1,0,0,1,0,1,1 -> each word held stable while ready=0; exactly 4 handshakes; order unchanged.
- Change mac_res_i to 0x12345678 one cycle after capture -> streamed words are still the snapshot values.
- DRAIN_LAT=0, NUM_PE=1: start, done with mac_res_i=5 -> valid next cycle, data=5, idx=0, last=1.
- done_i in IDLE; start_i during WAIT; done_i during STREAM -> one drop_o pulse each; no state or data disturbance.
- Assert rst_i asynchronously mid-STREAM after 2 handshakes -> clear_o=1, res_valid_o=0, busy_o=0 before the next edge; a fresh job afterwards streams from idx 0.
